palette_colorizer: RTL

//  Next-generation pixel colorizer: merges one world layer and NUM_ICONS icon layers into RGB.

---
 rtl/palette_colorizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/palette_colorizer.sv
// Merges one world layer and NUM_ICONS priority/blinking icon layers into RGB through a writable palette.
// Latency 2 clocks input->RGB, 1 pixel/clock; no backpressure (free-running pixel stream).
module palette_colorizer #(
    parameter int WORLD_BITS   = 2,
    parameter int ICON_BITS    = 2,
    parameter int NUM_ICONS    = 2,
    parameter int CH_W         = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int PAL_AW       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [WORLD_BITS-1:0]          world_px_i,
    input  logic [NUM_ICONS*ICON_BITS-1:0] icon_px_i,
    input  logic                           video_on_i,
    input  logic                           frame_tick_i,
    input  logic [NUM_ICONS-1:0]           blink_en_i,
    input  logic                           pal_we_i,
    input  logic [PAL_AW-1:0]              pal_addr_i,
    input  logic [3*CH_W-1:0]              pal_wdata_i,
    output logic                           pal_err_o,
    output logic                           video_out_o,
    output logic [CH_W-1:0]                red_o,
    output logic [CH_W-1:0]                green_o,
    output logic [CH_W-1:0]                blue_o
);

    localparam int WORLD_N   = 2**WORLD_BITS;
    localparam int ICON_N    = 2**ICON_BITS - 1;
    localparam int PAL_DEPTH = WORLD_N + NUM_ICONS*ICON_N;
    localparam int RGB_W     = 3*CH_W;
    localparam int CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PAL_AW:0] PAL_DEPTH_W = (PAL_AW+1)'(PAL_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLINK_FRAMES - 1);

    function automatic logic [RGB_W-1:0] pal_init(input int i);
        logic [CH_W-1:0] mx;
        logic [CH_W-1:0] z;
        int c;
        mx = '1;
        z  = '0;
        pal_init = '0;
        if (i < WORLD_N) begin
            if (i == 0)      pal_init = {mx, mx, mx};
            else if (i == 2) pal_init = {z, z, mx};
        end else begin
            c = (i - WORLD_N) % ICON_N + 1;
            if (c == 1)      pal_init = {mx, z, z};
            else if (c == 3) pal_init = {mx, mx, z};
        end
    endfunction

    logic [RGB_W-1:0]  pal_q [PAL_DEPTH];
    logic              addr_ok;
    logic              pal_err_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [PAL_AW-1:0] idx_d, idx_s1_q;
    logic              vid_s1_q;
    logic [RGB_W-1:0]  rgb_d, rgb_q;
    logic              vid_out_q;
    logic [ICON_BITS-1:0] code;

    assign addr_ok = ({1'b0, pal_addr_i} < PAL_DEPTH_W);

    // Writes land at the edge, so a stage-2 read in the same cycle still sees the old entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= pal_init(i);
            pal_err_q <= 1'b0;
        end else begin
            if (pal_we_i && addr_ok) pal_q[pal_addr_i] <= pal_wdata_i;
            pal_err_q <= pal_we_i && !addr_ok;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Scan from lowest priority upwards so icon 0 overwrites everything else.
    always_comb begin
        idx_d = PAL_AW'(world_px_i);
        code  = '0;
        for (int k = NUM_ICONS-1; k >= 0; k--) begin
            code = icon_px_i[k*ICON_BITS +: ICON_BITS];
            if (code != '0 && (!blink_en_i[k] || phase_q))
                idx_d = PAL_AW'(WORLD_N + k*ICON_N + int'(code) - 1);
        end
    end

    assign rgb_d = vid_s1_q ? pal_q[idx_s1_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            phase_q   <= 1'b1;
            idx_s1_q  <= '0;
            vid_s1_q  <= 1'b0;
            rgb_q     <= '0;
            vid_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            idx_s1_q  <= idx_d;
            vid_s1_q  <= video_on_i;
            rgb_q     <= rgb_d;
            vid_out_q <= vid_s1_q;
        end
    end

    assign pal_err_o   = pal_err_q;
    assign video_out_o = vid_out_q;
    assign red_o       = rgb_q[RGB_W-1 -: CH_W];
    assign green_o     = rgb_q[2*CH_W-1 -: CH_W];
    assign blue_o      = rgb_q[CH_W-1:0];

endmodule
